md_issue_stage: RTL
===================

// Module: md_issue_stage
// PURPOSE
//   Decode/issue stage for the HI/LO multiply-divide path of the 5-stage MIPS pipeline.
//   - Decodes the D-stage instruction word into the 4-bit mult/div op code (combinational).
//   - Registers op, operands and destination into the E stage, where the mult/div unit consumes them.
//   - Stall/flush rules follow the pipeline: D holds, E receives a bubble.
//   - Keeps a wrap-around count of issued long-latency ops for the perf/debug bus.
// PARAMETERS
//   CNT_W   32   width of md_issue_cnt
// PORTS
//   clk            in   1      single clock, rising edge
//   reset          in   1      asynchronous, active-high; clears all state
//   instr_d        in   32     D-stage instruction word
//   rs_val_d       in   32     D-stage rs value, already forwarded
//   rt_val_d       in   32     D-stage rt value, already forwarded
//   stall          in   1      global stall from hazard unit (includes mult/div busy stall)
//   flush_e        in   1      kill the instruction entering E this cycle
//   xaluop_d       out  4      decoded op in D (combinational), to mult/div busy check
//   xaluop_e       out  4      registered op in E, to mult/div unit
//   numa_e         out  32     registered rs value
//   numb_e         out  32     registered rt value
//   md_rd_e        out  5      GPR destination for mfhi/mflo, else 0
//   md_wen_e       out  1      1 when E holds mfhi/mflo (GPR write of HI/LO)
//   md_issue_cnt   out  CNT_W  count of mult/multu/div/divu ops that entered E
// BEHAVIOUR
//   Op codes:
//     0 none     1 mtlo   2 mthi   3 divu   4 div
//     5 multu    6 mult   7 mflo   8 mfhi   9-15 unused
//   Decode:
//     - Only applies when opcode instr_d[31:26] = 6'b000000.
//     - Funct map: 0x10->8, 0x11->2, 0x12->7, 0x13->1, 0x18->6, 0x19->5, 0x1A->4, 0x1B->3.
//     - Any other opcode or funct decodes to 0.
//   E register update, rising clk:
//     - reset = 1 (async): xaluop_e, numa_e, numb_e, md_rd_e, md_wen_e, md_issue_cnt all 0.
//     - else if stall | flush_e: load a bubble.
//       - xaluop_e = 0, md_wen_e = 0, md_rd_e = 0.
//       - numa_e and numb_e are also cleared to 0.
//       - The D instruction is re-presented next cycle; this block holds no D-side copy.
//     - else load from D:
//       - xaluop_e <= xaluop_d, numa_e <= rs_val_d, numb_e <= rt_val_d.
//       - md_wen_e <= (xaluop_d == 7 || xaluop_d == 8).
//       - md_rd_e <= md_wen_e_next ? instr_d[15:11] : 0.
//   Issue counter:
//     - Increments by 1 only when an op in 3..6 is loaded into E (not on bubble cycles).
//     - Wraps from all-ones to 0.
//   Latency: exactly 1 cycle from D to E; no internal buffering beyond the E register.
//   Boundary conditions:
//     - stall and flush_e together: one bubble, identical to either alone.
//     - Back-to-back mult/div in D while E is busy: the busy stall gives bubbles; one issue per instruction.
//       Each op is seen by the mult/div unit for exactly one E cycle, never a duplicate.
//     - Reset mid-stall: E becomes a bubble immediately (async); the counter returns to 0.
//     - rd field of mfhi/mflo = 0: md_wen_e = 1 and md_rd_e = 0; the writeback stage discards it.
//     - Operands are passed raw; no divide-by-zero check (architecturally undefined HI/LO).
// STRUCTURE
//   Shared package/header: op-code constants MD_NONE..MD_MFHI (0..8) and funct constants.
//   The mult/div unit and the control decoder use the same constants.
//   One sub-module: md_decode (pure combinational instr -> op code), reused by the hazard unit.
//   The E register and counter are in this file.
// TESTING
//   1. instr_d = 0x00850018 (mult a0,a1), rs = 0xFFFFFFFE, rt = 3, no stall
//      -> xaluop_d = 6 at once; next edge xaluop_e = 6, numa_e = 0xFFFFFFFE, numb_e = 3, cnt = 1.
//   2. instr_d = 0x00004010 (mfhi t0)
//      -> xaluop_d = 8; next edge xaluop_e = 8, md_wen_e = 1, md_rd_e = 8; cnt unchanged.
//   3. div in D with stall = 1 for 3 cycles, then 0
//      -> 3 cycles of xaluop_e = 0, then one cycle of 4; cnt increments once.
//   4. mthi in D with flush_e = 1 and stall = 1 together
//      -> xaluop_e = 0, numa_e = 0, md_wen_e = 0.
//   5. Preset cnt to all-ones (2^CNT_W - 1), issue multu
//      -> md_issue_cnt = 0.
//   6. Assert reset asynchronously between edges with xaluop_e = 5
//      -> all outputs 0 before the next clk edge.
//   7. instr_d = 0x8C000000 (lw) and funct-0x2A SPECIAL (slt)
//      -> xaluop_d = 0 for both.

Source files
------------

// File: rtl/md_issue_stage_pkg.sv
// Shared op-code and funct constants for the HI/LO multiply-divide path.
// The decoder, the issue stage and the mult/div unit all import this package.
package md_issue_stage_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MTLO  = 4'd1,
        MD_MTHI  = 4'd2,
        MD_DIVU  = 4'd3,
        MD_DIV   = 4'd4,
        MD_MULTU = 4'd5,
        MD_MULT  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MFHI  = 4'd8
    } md_op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Ops that occupy the mult/div unit for many cycles.
    function automatic logic md_is_long(input logic [3:0] op);
        return (op >= MD_DIVU) && (op <= MD_MULT);
    endfunction

    // Ops that write HI or LO back into the GPR file.
    function automatic logic md_is_mf(input logic [3:0] op);
        return (op == MD_MFLO) || (op == MD_MFHI);
    endfunction

endpackage

// File: rtl/md_issue_stage_decode.sv
// Pure combinational decode of the SPECIAL opcode/funct fields into a mult/div op.
// Shared with the hazard unit so both agree on what counts as a mult/div op.
module md_decode
    import md_issue_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] xaluop
);

    md_op_e op;

    always_comb begin
        op = MD_NONE;
        if (opcode == OPC_SPECIAL) begin
            unique case (funct)
                FN_MFHI:  op = MD_MFHI;
                FN_MTHI:  op = MD_MTHI;
                FN_MFLO:  op = MD_MFLO;
                FN_MTLO:  op = MD_MTLO;
                FN_MULT:  op = MD_MULT;
                FN_MULTU: op = MD_MULTU;
                FN_DIV:   op = MD_DIV;
                FN_DIVU:  op = MD_DIVU;
                default:  op = MD_NONE;
            endcase
        end
    end

    assign xaluop = op;

endmodule

// File: rtl/md_issue_stage.sv
// D->E issue register for the HI/LO multiply-divide path, plus a wrap-around
// count of long-latency ops that reached E.
module md_issue_stage
    import md_issue_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      rs_val_d,
    input  logic [31:0]      rt_val_d,
    input  logic             stall,
    input  logic             flush_e,
    output logic [3:0]       xaluop_d,
    output logic [3:0]       xaluop_e,
    output logic [31:0]      numa_e,
    output logic [31:0]      numb_e,
    output logic [4:0]       md_rd_e,
    output logic             md_wen_e,
    output logic [CNT_W-1:0] md_issue_cnt
);

    logic       bubble;
    logic       md_wen_e_next;
    logic [4:0] md_rd_e_next;
    logic       unused_instr_bits;

    md_decode u_decode (
        .opcode (instr_d[31:26]),
        .funct  (instr_d[5:0]),
        .xaluop (xaluop_d)
    );

    // rs/rt/shamt fields are consumed upstream as forwarded values.
    assign unused_instr_bits = ^{instr_d[25:16], instr_d[10:6]};

    assign bubble        = stall | flush_e;
    assign md_wen_e_next = md_is_mf(xaluop_d);
    assign md_rd_e_next  = md_wen_e_next ? instr_d[15:11] : 5'd0;

    // A stalled D instruction is re-presented, so a bubble here never loses it
    // and never lets the mult/div unit see the same op twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xaluop_e <= MD_NONE;
            numa_e   <= '0;
            numb_e   <= '0;
            md_rd_e  <= '0;
            md_wen_e <= 1'b0;
        end else if (bubble) begin
            xaluop_e <= MD_NONE;
            numa_e   <= '0;
            numb_e   <= '0;
            md_rd_e  <= '0;
            md_wen_e <= 1'b0;
        end else begin
            xaluop_e <= xaluop_d;
            numa_e   <= rs_val_d;
            numb_e   <= rt_val_d;
            md_rd_e  <= md_rd_e_next;
            md_wen_e <= md_wen_e_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_issue_cnt <= '0;
        else if (!bubble && md_is_long(xaluop_d))
            md_issue_cnt <= md_issue_cnt + 1'b1;
    end

endmodule
